// File: rtl/contador_pkg.sv
// Shared types and helpers for the multi-channel pop counter bank.
// Optional build macro: CONTADOR_CLEAR_ON_READ_EN (clear-on-read counters).
package contador_pkg;

    typedef enum logic {
        COUNT = 1'b0,
        READ  = 1'b1
    } state_t;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 5;

    // Index width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/contador_multicanal_if.sv
// Readout handshake bundle: request/index in, valid/value/error out.
interface contador_multicanal_if #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 5
);
    logic             req;
    logic [IDX_W-1:0] idx;
    logic             valid_contador;
    logic [CNT_W-1:0] contador_out;
    logic             idx_err;

    // Requester side.
    modport master (
        output req,
        output idx,
        input  valid_contador,
        input  contador_out,
        input  idx_err
    );

    // Counter bank side.
    modport slave (
        input  req,
        input  idx,
        output valid_contador,
        output contador_out,
        output idx_err
    );
endinterface

// File: rtl/contador_canal.sv
// Single channel counter: optional clear, then optional increment,
// either wrapping or saturating at all-ones.
module contador_canal #(
    parameter int CNT_W    = 5,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] base;

    // Clear takes effect first so a same-cycle increment lands on zero.
    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i) begin
            if (SATURATE && (&base)) begin
                cnt_d = base;
            end else begin
                cnt_d = base + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/contador_multicanal.sv
// Bank of per-channel pop counters with an indexed readout handshake that
// is only open while the system is idle, plus a registered drained flag.
// Build macro CONTADOR_CLEAR_ON_READ_EN: an accepted read clears the
// selected counter; otherwise reads are non-destructive.
module contador_multicanal
    import contador_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int IDX_W    = clog2_min1(N_CH),
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       pop,
    input  logic [N_CH-1:0]       empty,
    input  logic                  idle,
    contador_multicanal_if.slave  rd,
    output logic                  drained
);

    state_t           state_q, state_d;
    logic             accept;
    logic             in_range;
    logic [CNT_W-1:0] sel_cnt;
    logic [CNT_W-1:0] cnt_w [N_CH];
    logic [N_CH-1:0]  clr_w;

    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic             drained_q, drained_d;

    // A request is taken only in READ while idle is still high.
    assign accept   = (state_q == READ) && idle && rd.req;
    assign in_range = (int'(rd.idx) < N_CH);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_canal
`ifdef CONTADOR_CLEAR_ON_READ_EN
            assign clr_w[gi] = accept && (int'(rd.idx) == gi);
`else
            assign clr_w[gi] = 1'b0;
`endif
            contador_canal #(
                .CNT_W    (CNT_W),
                .SATURATE (SATURATE)
            ) u_canal (
                .clk   (clk),
                .reset (reset),
                .inc_i (pop[gi]),
                .clr_i (clr_w[gi]),
                .cnt_o (cnt_w[gi])
            );
        end
    endgenerate

    // Index mux; an out-of-range index matches nothing and yields zero.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(rd.idx) == i) begin
                sel_cnt = cnt_w[i];
            end
        end
    end

    // Next state: enter READ once idle, leave as soon as idle drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COUNT:   if (idle)  state_d = READ;
            READ:    if (!idle) state_d = COUNT;
            default: state_d = COUNT;
        endcase
    end

    // Output next values: pulse valid/err on accept, hold value otherwise.
    always_comb begin
        valid_d   = accept;
        err_d     = accept && !in_range;
        out_d     = out_q;
        drained_d = idle & (&empty);
        if (accept) begin
            out_d = in_range ? sel_cnt : '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= COUNT;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            out_q     <= '0;
            drained_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            out_q     <= out_d;
            drained_q <= drained_d;
        end
    end

    assign rd.valid_contador = valid_q;
    assign rd.idx_err        = err_q;
    assign rd.contador_out   = out_q;
    assign drained           = drained_q;

endmodule

// File: tb/tb_contador_multicanal.sv
// Directed bench: wrap-mode 4-channel bank, saturating 4-channel bank and a
// 3-channel bank driven from the same stimulus.
module tb_contador_multicanal;

    logic       clk;
    logic       reset;
    logic [3:0] pop;
    logic [3:0] empty;
    logic       idle;
    logic       req;
    logic [1:0] idx;
    logic       drained_a, drained_s, drained_c;

    int checks;
    int failures;

    contador_multicanal_if #(.IDX_W(2), .CNT_W(5)) if_a ();
    contador_multicanal_if #(.IDX_W(2), .CNT_W(5)) if_s ();
    contador_multicanal_if #(.IDX_W(2), .CNT_W(5)) if_c ();

    assign if_a.req = req;
    assign if_a.idx = idx;
    assign if_s.req = req;
    assign if_s.idx = idx;
    assign if_c.req = req;
    assign if_c.idx = idx;

    contador_multicanal #(.N_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(1'b0)) dut_a (
        .clk(clk), .reset(reset), .pop(pop), .empty(empty), .idle(idle),
        .rd(if_a.slave), .drained(drained_a)
    );

    contador_multicanal #(.N_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .pop(pop), .empty(empty), .idle(idle),
        .rd(if_s.slave), .drained(drained_s)
    );

    contador_multicanal #(.N_CH(3), .CNT_W(5), .IDX_W(2), .SATURATE(1'b0)) dut_c (
        .clk(clk), .reset(reset), .pop(pop[2:0]), .empty(empty[2:0]), .idle(idle),
        .rd(if_c.slave), .drained(drained_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pop   = '0;
        empty = '0;
        idle  = 1'b0;
        req   = 1'b0;
        idx   = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset state
        do_reset();
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(if_a.valid_contador), 0);
        check("rst_out",   32'(if_a.contador_out),   0);
        check("rst_err",   32'(if_a.idx_err),        0);
        check("rst_drained", 32'(drained_a),         0);
        $display("txn reset: valid=%0d out=%0d", if_a.valid_contador, if_a.contador_out);

        // Test 1: three pops on ch0, then read idx 0
        do_reset();
        pop = 4'b0001;
        tick(); tick(); tick();
        pop  = '0;
        idle = 1'b1;
        tick();
        req = 1'b1; idx = 2'd0;
        tick();
        check("t1_valid", 32'(if_a.valid_contador), 1);
        check("t1_out",   32'(if_a.contador_out),   3);
        check("t1_err",   32'(if_a.idx_err),        0);
        $display("txn t1 read idx=0: out=%0d", if_a.contador_out);
        req = 1'b0;
        tick();
        check("t1_valid_drop", 32'(if_a.valid_contador), 0);
        check("t1_out_hold",   32'(if_a.contador_out),   3);

        // Test 2 and 5: ch1=1, ch2=3, ch3=1, back-to-back reads
        do_reset();
        pop = 4'b1110;
        tick();
        pop = 4'b0100;
        tick(); tick();
        pop  = '0;
        idle = 1'b1;
        tick();
        req = 1'b1; idx = 2'd1;
        tick();
        check("t2_valid1", 32'(if_a.valid_contador), 1);
        check("t2_out1",   32'(if_a.contador_out),   1);
        $display("txn t2 read idx=1: out=%0d", if_a.contador_out);
        idx = 2'd2;
        tick();
        check("t2_valid2", 32'(if_a.valid_contador), 1);
        check("t2_out2",   32'(if_a.contador_out),   3);
        $display("txn t2 read idx=2: out=%0d", if_a.contador_out);
        idx = 2'd3;
        tick();
        check("t2_valid3", 32'(if_a.valid_contador), 1);
        check("t2_out3",   32'(if_a.contador_out),   1);
        check("t2_err3",   32'(if_a.idx_err),        0);
        check("t5_valid",  32'(if_c.valid_contador), 1);
        check("t5_out",    32'(if_c.contador_out),   0);
        check("t5_err",    32'(if_c.idx_err),        1);
        $display("txn t2/t5 read idx=3: out4=%0d out3=%0d err3=%0d",
                 if_a.contador_out, if_c.contador_out, if_c.idx_err);
        req = 1'b0;
        tick();
        check("t2_valid_end", 32'(if_a.valid_contador), 0);
        check("t5_err_end",   32'(if_c.idx_err),        0);

        // Test 3: 33 pops on ch2, wrap vs saturate
        do_reset();
        pop = 4'b0100;
        for (int i = 0; i < 33; i++) tick();
        pop  = '0;
        idle = 1'b1;
        tick();
        req = 1'b1; idx = 2'd2;
        tick();
        check("t3_wrap", 32'(if_a.contador_out), 1);
        check("t3_sat",  32'(if_s.contador_out), 31);
        $display("txn t3 read idx=2: wrap=%0d sat=%0d", if_a.contador_out, if_s.contador_out);

        // Test 4: request in the cycle idle drops, and in the cycle idle rises
        idle = 1'b0; req = 1'b1; idx = 2'd1;
        tick();
        check("t4_drop_valid", 32'(if_a.valid_contador), 0);
        check("t4_drop_out",   32'(if_a.contador_out),   1);
        idle = 1'b1;
        tick();
        check("t4_rise_valid", 32'(if_a.valid_contador), 0);
        check("t4_rise_out",   32'(if_a.contador_out),   1);
        tick();
        check("t4_acc_valid", 32'(if_a.valid_contador), 1);
        check("t4_acc_out",   32'(if_a.contador_out),   0);
        $display("txn t4 read idx=1: out=%0d", if_a.contador_out);
        req = 1'b0;

        // Drained flag
        empty = 4'hF;
        tick();
        check("drained_set", 32'(drained_a), 1);
        empty = 4'hE;
        tick();
        check("drained_partial", 32'(drained_a), 0);
        empty = 4'hF; idle = 1'b0;
        tick();
        check("drained_busy", 32'(drained_a), 0);
        $display("txn drained: final=%0d", drained_a);

        // Test 6: read with a same-cycle pop, then reset mid-readout
        do_reset();
        pop = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        pop  = '0;
        idle = 1'b1;
        tick();
        req = 1'b1; idx = 2'd0; pop = 4'b0001;
        tick();
        check("t6_valid", 32'(if_a.valid_contador), 1);
        check("t6_out",   32'(if_a.contador_out),   5);
        $display("txn t6 read idx=0: out=%0d", if_a.contador_out);
        req = 1'b0; pop = '0;
        tick();
        req = 1'b1;
        tick();
`ifdef CONTADOR_CLEAR_ON_READ_EN
        check("t6_second", 32'(if_a.contador_out), 1);
`else
        check("t6_second", 32'(if_a.contador_out), 6);
`endif
        $display("txn t6 second read idx=0: out=%0d", if_a.contador_out);
        tick();
        check("t6_pending", 32'(if_a.valid_contador), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(if_a.valid_contador), 0);
        check("t6_rst_out",   32'(if_a.contador_out),   0);
        check("t6_rst_err",   32'(if_a.idx_err),        0);
        $display("txn t6 reset mid-read: valid=%0d out=%0d", if_a.valid_contador, if_a.contador_out);
        reset = 1'b1;
        req   = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
